fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the hazard unit and the decode stage.
- Owns the PC register and the IF/ID pipeline register.
- Runs a single-outstanding-request handshake to instruction memory with variable response latency.
- Consumes stall_f, stall_d, flush_d from the hazard unit and pc_src_e / pc_target_e from execute.
- Reports memory-wait via fetch_wait so the hazard logic can account for it.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on bubble or flush (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
stall_f  input  1  hold PC (from hazard unit)
stall_d  input  1  hold IF/ID register (from hazard unit)
flush_d  input  1  clear IF/ID to bubble (from hazard unit)
pc_src_e  input  1  taken branch/jump in execute
pc_target_e  input  32  redirect target
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_ack  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID PC
pc_plus4_d  output  32  IF/ID PC+4
valid_d  output  1  IF/ID holds a real instruction
fetch_wait  output  1  no instruction available for decode this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc_f=RESET_PC, state=IDLE, hold_valid=0.
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
  - imem_req=0, fetch_wait=1.
- States: IDLE, REQ, WAIT, HOLD, DROP. Outputs below are Moore unless noted.
  - IDLE: one cycle after reset release, then REQ. imem_rvalid ignored.
  - REQ: imem_req=1, imem_addr={pc_f[31:2],2'b00}.
    - imem_ack -> WAIT.
    - Without ack, address may change only on redirect; stay in REQ.
  - WAIT: waiting for imem_rvalid. On rvalid:
    - if !stall_d: load IF/ID (instr_d=imem_rdata, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1), pc_f<=pc_f+4, -> REQ.
    - if stall_d: capture into hold buffer, -> HOLD.
  - HOLD: IF/ID frozen. When !stall_d: transfer hold buffer to IF/ID, pc_f<=pc_f+4, -> REQ.
  - DROP: discard next imem_rvalid, then -> REQ at the current pc_f.
- Bubble: if !stall_d, !flush_d and no instruction delivered this cycle, IF/ID loads instr_d=NOP_INSTR, valid_d=0; pc_d and pc_plus4_d hold their previous values.
- fetch_wait=1 in every cycle in which IF/ID cannot be loaded with a real instruction (combinational).
- stall_f: pc_f is not incremented and the hold buffer is not released to IF/ID, even if stall_d is low.
- flush_d: IF/ID <= bubble (NOP_INSTR, valid_d=0). Priority over stall_d.
- Redirect (pc_src_e=1), priority over stall_f:
  - pc_f<=pc_target_e with bits [1:0] forced to 0; hold_valid cleared.
  - From REQ without ack -> REQ at new address next cycle.
  - From REQ with ack, or WAIT without rvalid -> DROP.
  - From WAIT with rvalid (response discarded), HOLD, DROP-with-rvalid, or IDLE -> REQ.
  - Redirect while in DROP without rvalid stays in DROP.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Latency: imem_ack and imem_rvalid in consecutive cycles give one instruction per 2 cycles. Back-to-back fetch is not required.
- imem_rvalid in IDLE or REQ is a protocol error; ignore it.

Decomposition:
- Shared pipeline package holds NOP_INSTR, the fetch_state_t enum (IDLE/REQ/WAIT/HOLD/DROP) and the IF/ID struct type {instr, pc, pc_plus4, valid}. Decode and hazard logic reuse the struct.
- Natural sub-module: if_id_reg, the IF/ID register with load/hold/flush controls and bubble insertion.
- FSM and PC stay in fetch_stage.

Test Plan:
- Reset release, imem_ack same cycle as req, rvalid next cycle, rdata=32'h00500093 -> imem_addr=0; then instr_d=00500093, pc_d=0, pc_plus4_d=4, valid_d=1; next imem_addr=4.
- rvalid arrives with stall_d=1 for 3 cycles -> IF/ID unchanged for 3 cycles (HOLD); instruction appears the cycle after stall_d falls; pc_f advances by exactly 4.
- pc_src_e=1, pc_target_e=32'h0000_0102 during WAIT; the next rvalid carries 32'hDEADBEEF -> DEADBEEF never reaches instr_d; next imem_addr=32'h0000_0100.
- flush_d=1 together with stall_d=1 -> instr_d=00000013, valid_d=0 next cycle.
- imem_ack withheld 5 cycles -> imem_req and imem_addr stable; valid_d=0 and fetch_wait=1 throughout.
- rst_n pulsed low while in WAIT, then stale rvalid arrives -> outputs at reset values immediately; stale data ignored; first request after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared IF-stage types: fetch FSM states, the IF/ID record and the bubble instruction.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register, 1-cycle latency: flush beats stall, stall freezes, and an
// unloaded cycle inserts a bubble while keeping the previous PC fields.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   stall,
  input  logic   load,
  input  if_id_t din,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.instr    <= BUBBLE_INSTR;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
      q.valid    <= 1'b0;
    end else if (flush || (!stall && !load)) begin
      q.instr <= BUBBLE_INSTR;
      q.valid <= 1'b0;
    end else if (!stall) begin
      q <= din;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch: PC + single-outstanding imem handshake, at best one instruction per 2 cycles;
// a response that decode cannot take is parked in a one-entry hold buffer until stalls clear.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_wait
);

  import fetch_stage_pkg::*;

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_f;
  logic [31:0]  hold_instr;
  logic         hold_valid;
  logic         take;
  logic         rsp;
  logic         deliver;
  logic         capture;
  if_id_t       if_id_din;
  if_id_t       if_id_q;

  // Decode can accept only when nothing upstream or downstream is holding it off.
  assign take    = !stall_d && !stall_f && !flush_d;
  assign rsp     = (state == WAIT) && imem_rvalid;
  assign deliver = !pc_src_e && take && (rsp || hold_valid);
  assign capture = rsp && !pc_src_e && !take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (imem_ack) state_nxt = pc_src_e ? DROP : WAIT;
      WAIT: begin
        if (imem_rvalid)   state_nxt = (pc_src_e || take) ? REQ : HOLD;
        else if (pc_src_e) state_nxt = DROP;
      end
      HOLD: if (pc_src_e || take) state_nxt = REQ;
      DROP: if (imem_rvalid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state == REQ);
    imem_addr  = word_align(pc_f);
    fetch_wait = !deliver;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f       <= RESET_PC;
      hold_instr <= NOP_INSTR;
      hold_valid <= 1'b0;
    end else begin
      if (pc_src_e)     pc_f <= word_align(pc_target_e);
      else if (deliver) pc_f <= pc_f + 32'd4;

      if (pc_src_e || deliver) begin
        hold_valid <= 1'b0;
      end else if (capture) begin
        hold_valid <= 1'b1;
        hold_instr <= imem_rdata;
      end
    end
  end

  assign if_id_din = '{instr:    hold_valid ? hold_instr : imem_rdata,
                       pc:       pc_f,
                       pc_plus4: pc_f + 32'd4,
                       valid:    1'b1};

  fetch_stage_if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush_d),
    .stall(stall_d),
    .load (deliver),
    .din  (if_id_din),
    .q    (if_id_q)
  );

  assign instr_d    = if_id_q.instr;
  assign pc_d       = if_id_q.pc;
  assign pc_plus4_d = if_id_q.pc_plus4;
  assign valid_d    = if_id_q.valid;

endmodule
